// File: rtl/dmem_slave.sv
// -----------------------------------------------------------------------------
// dmem_slave
// Single-port data memory slave for the CPU MEM stage. Accepts one request at
// a time, inserts WAIT_CYC wait states, then acknowledges for one cycle.
// Writes honour byte enables; misaligned accesses ack with err and do nothing.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words held
//   WAIT_CYC   : wait-state cycles between accept and ack (0..15)
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset (control state only)
//   req    in   request strobe
//   we     in   1 = write, 0 = read
//   addr   in   [31:0] byte address
//   wdata  in   [31:0] write data
//   be     in   [3:0]  byte enables, be[i] -> bits 8i+7..8i
//   ack    out  transaction completes this cycle
//   rdata  out  [31:0] read data, zero unless ack
//   err    out  misaligned access, only with ack
//   busy   out  transaction in progress
//
// Optional build macro
//   DMEM_SLAVE_WRITE_LOG_EN : prints every committed write (simulation only)
//
// FSM states
//   state | meaning
//   IDLE  | no transaction; accepts req and latches the request
//   WAIT  | counting down wait states
//   RESP  | single ack cycle, then back to IDLE
// -----------------------------------------------------------------------------
module dmem_slave #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] rdata_q;
  logic        err_q;

  logic load;
  logic enter_resp;

  logic [31:0] mem [DEPTH];

  // The edge that enters RESP may be the accept edge itself (WAIT_CYC=0), in
  // which case the request has not been latched yet; select the live inputs.
  logic                  cur_we;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_be;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  cur_aligned;
  logic [31:0]           mem_word;
  logic [31:0]           merged;
  logic                  commit;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          load  = 1'b1;
          cnt_d = WAIT_INIT;
          if (WAIT_CYC == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted count can never stall here
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath selection and byte merge
  // --------------------------------------------------------------------------
  always_comb begin
    cur_we    = load ? we    : lat_we;
    cur_addr  = load ? addr  : lat_addr;
    cur_wdata = load ? wdata : lat_wdata;
    cur_be    = load ? be    : lat_be;
  end

  assign cur_idx     = cur_addr[DEPTH_LOG2+1:2];
  assign cur_aligned = (cur_addr[1:0] == 2'b00);
  assign mem_word    = mem[cur_idx];

  always_comb begin
    merged = mem_word;
    for (int i = 0; i < 4; i++) begin
      if (cur_be[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
    end
  end

  // Gated by reset so that nothing lands while the block is held in reset.
  assign commit = reset & enter_resp & cur_we & cur_aligned;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_be    <= be;
      end
      if (enter_resp) begin
        rdata_q <= (!cur_we && cur_aligned) ? mem_word : 32'd0;
        err_q   <= !cur_aligned;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: deliberately not reset, contents survive reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_idx] <= merged;
`ifdef DMEM_SLAVE_WRITE_LOG_EN
      $display("%0t@: *%08h <= %08h", $time, cur_addr, merged);
`else
`endif
    end
  end

  // Upper address bits only matter to the write log.
  logic unused_addr_hi;
  assign unused_addr_hi = ^lat_addr[31:DEPTH_LOG2+2];

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = ack ? rdata_q : 32'd0;
  assign err   = ack & err_q;

endmodule

// File: tb/tb_dmem_slave.sv
// Bench for dmem_slave: instance 0 uses WAIT_CYC=0, instance 1 WAIT_CYC=2.
module tb_dmem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        busy  [2];

  always #5 clk = ~clk;

  dmem_slave #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ack(ack[0]), .rdata(rdata[0]),
    .err(err[0]), .busy(busy[0])
  );

  dmem_slave #(.DEPTH_LOG2(10), .WAIT_CYC(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ack(ack[1]), .rdata(rdata[1]),
    .err(err[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: word index is the byte address divided by 4, modulo 1024.
  logic [31:0] mm [2][1024];

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_txn(input int s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output logic [31:0] er, output logic ee);
    int idx;
    idx = int'((a / 4) % 1024);
    er  = 32'd0;
    ee  = 1'b0;
    if (a % 4 != 0) begin
      ee = 1'b1;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mm[s][idx][8*i +: 8] = d[8*i +: 8];
    end else begin
      er = mm[s][idx];
    end
  endtask

  // One transaction; after acceptance the inputs are scrambled to show that
  // only the latched request matters.
  task automatic do_txn(input string tag, input int s, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_rd,
                        input logic exp_err);
    int          lat;
    logic [31:0] got_rd;
    logic        got_err;
    logic        bad_busy;
    logic        bad_idle_out;
    lat = 0; got_rd = 32'd0; got_err = 1'b0; bad_busy = 1'b0; bad_idle_out = 1'b0;
    @(negedge clk);
    req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b;
    @(posedge clk);
    #1;
    req[s] = 1'b0; we[s] = ~w; addr[s] = $urandom; wdata[s] = $urandom;
    be[s] = 4'($urandom);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack[s]) begin
        lat = n; got_rd = rdata[s]; got_err = err[s];
        break;
      end
      if (!busy[s]) bad_busy = 1'b1;
      if (rdata[s] != 32'd0 || err[s]) bad_idle_out = 1'b1;
    end
    chk({tag, " latency"}, lat, wait_of(s) + 1);
    chk({tag, " rdata"}, got_rd, exp_rd);
    chk({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    chk({tag, " busy in wait"}, {31'd0, bad_busy}, 32'd0);
    chk({tag, " outputs quiet before ack"}, {31'd0, bad_idle_out}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " busy after resp"}, {31'd0, busy[s]}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] er;
    logic        ee;
    logic        flag;

    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0; be[s] = 4'd0;
    end

    //            we    addr          wdata         be       exp_rdata     err
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'b1111, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0014, 32'h1122_3344, 4'b0101, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,         4'b0000, 32'hAA22_CC44, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 4'b1111, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b1111, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,         4'b1111, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0018, 32'h0102_0304, 4'b1111, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0018, 32'hCAFE_F00D, 4'b0000, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_0018, 32'h0,         4'b1111, 32'h0102_0304, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_101C, 32'h55AA_55AA, 4'b1111, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_001C, 32'h0,         4'b1111, 32'h55AA_55AA, 1'b0};

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset ack%0d", s), {31'd0, ack[s]}, 32'd0);
      chk($sformatf("reset err%0d", s), {31'd0, err[s]}, 32'd0);
      chk($sformatf("reset busy%0d", s), {31'd0, busy[s]}, 32'd0);
      chk($sformatf("reset rdata%0d", s), rdata[s], 32'd0);
    end
    reset = 1'b1;

    // Directed table on the WAIT_CYC=2 instance
    for (int i = 0; i < 13; i++)
      do_txn($sformatf("vec%0d", i), 1, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset during WAIT of a write aborts it
    do_txn("rst prep", 1, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEAD_BEEF; be[1] = 4'hF;
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    chk("rst busy in wait", {31'd0, busy[1]}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rst busy immediate", {31'd0, busy[1]}, 32'd0);
    chk("rst ack immediate", {31'd0, ack[1]}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst held rdata", rdata[1], 32'd0);
    reset = 1'b1;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ack[1] || busy[1]) flag = 1'b1;
    end
    chk("rst no late ack", {31'd0, flag}, 32'd0);
    do_txn("rst readback", 1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0);

    // Back-to-back with req held high, WAIT_CYC=0, address wrap
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h1004; wdata[0] = 32'h5EED_1234; be[0] = 4'hF;
    @(posedge clk);
    #1;
    we[0] = 1'b0; addr[0] = 32'h0004; wdata[0] = 32'h0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("b2b ack cycle%0d", n), {31'd0, ack[0]}, (n % 2 == 0) ? 32'd1 : 32'd0);
      if (n > 0)
        chk($sformatf("b2b rdata cycle%0d", n), rdata[0], (n % 2 == 0) ? 32'h5EED_1234 : 32'h0);
    end
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic against the reference model on both instances
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) begin
        logic [31:0] d;
        logic [31:0] a;
        d = $urandom;
        a = 32'h400 + 32'(4 * k);
        model_txn(s, 1'b1, a, d, 4'hF, er, ee);
        do_txn($sformatf("init%0d_%0d", s, k), s, 1'b1, a, d, 4'hF, er, ee);
      end
      for (int t = 0; t < 100; t++) begin
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        w = 1'($urandom);
        a = ($urandom_range(0, 15) << 12) | (32'h400 + 32'(4 * $urandom_range(0, 15)));
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        d = $urandom;
        b = 4'($urandom);
        model_txn(s, w, a, d, b, er, ee);
        do_txn($sformatf("rand%0d_%0d", s, t), s, w, a, d, b, er, ee);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
